router_fsm: RTL and testbench

- Control state machine for the 1x3 router. It sequences the register/datapath block: header detect, header load, payload load, FIFO-full stall, parity capture and parity check.
- Decodes the 2-bit destination address from the header byte, and waits for the destination FIFO to drain before accepting a packet.
- Sits between the input interface and the register block / synchroniser. It drives detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg and busy.

---
 rtl/router_fsm.sv | 126 ++++++++++++
 tb/tb_router_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: decodes the header address, waits for the
// destination FIFO, and sequences header/payload/parity loading and FIFO-full stalls.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic       w_hdr_ok;
  logic       w_empty_hdr;
  logic       w_empty_sel;
  logic       w_soft_sel;

  assign w_hdr_ok = pkt_valid && (data_in != 2'b11);

  // Header-time empty flag comes from the live address; afterwards from the latched one.
  always_comb begin
    w_empty_hdr = 1'b0;
    w_empty_sel = 1'b0;
    w_soft_sel  = 1'b0;
    case (data_in)
      2'd0:    w_empty_hdr = fifo_empty_0;
      2'd1:    w_empty_hdr = fifo_empty_1;
      2'd2:    w_empty_hdr = fifo_empty_2;
      default: w_empty_hdr = 1'b0;
    endcase
    case (r_addr)
      2'd0:    begin w_empty_sel = fifo_empty_0; w_soft_sel = soft_reset_0; end
      2'd1:    begin w_empty_sel = fifo_empty_1; w_soft_sel = soft_reset_1; end
      2'd2:    begin w_empty_sel = fifo_empty_2; w_soft_sel = soft_reset_2; end
      default: begin w_empty_sel = 1'b0;         w_soft_sel = 1'b0;         end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= DA;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == DA && w_hdr_ok)
        r_addr <= data_in;
    end
  end

  always_comb begin
    w_next        = r_state;
    write_enb_reg = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;

    // A read-timeout soft reset on the selected FIFO abandons the packet from any state.
    if (r_state != DA && w_soft_sel) begin
      w_next = DA;
    end else begin
      case (r_state)
        DA:  if (w_hdr_ok) w_next = w_empty_hdr ? LFD : WTE;
        LFD: w_next = LD;
        LD: begin
          if (fifo_full)       w_next = FFS;
          else if (!pkt_valid) w_next = LP;
        end
        FFS: if (!fifo_full) w_next = LAF;
        LAF: begin
          if (parity_done)        w_next = DA;
          else if (low_pkt_valid) w_next = LP;
          else                    w_next = LD;
        end
        LP:  w_next = CPE;
        CPE: w_next = fifo_full ? FFS : DA;
        WTE: if (w_empty_sel) w_next = LFD;
        default: w_next = DA;
      endcase
    end

    case (r_state)
      DA:  detect_add = 1'b1;
      LFD: begin lfd_state = 1'b1; busy = 1'b1; end
      LD:  begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      FFS: begin full_state = 1'b1; busy = 1'b1; end
      LAF: begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
      LP:  begin write_enb_reg = 1'b1; busy = 1'b1; end
      CPE: begin rst_int_reg = 1'b1; busy = 1'b1; end
      WTE: busy = 1'b1;
      default: detect_add = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed scenarios against literal phase expectations,
// then randomized traffic against a behavioural packet-phase model.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       write_enb_reg, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg, busy;
  logic [7:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  localparam int P_DA  = 100;
  localparam int P_LFD = 101;
  localparam int P_LD  = 102;
  localparam int P_FFS = 103;
  localparam int P_LAF = 104;
  localparam int P_LP  = 105;
  localparam int P_CPE = 106;
  localparam int P_WTE = 107;

  int       m_phase;
  int       m_addr;
  logic [2:0] m_empty;
  logic [2:0] m_soft;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  assign outs    = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};
  assign m_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign m_soft  = {soft_reset_2, soft_reset_1, soft_reset_0};

  // Expected output vector for a packet phase: {we, da, lfd, ld, laf, ffs, rst_int, busy}
  function automatic logic [7:0] outs_of(int p);
    return {(p == P_LD || p == P_LP || p == P_LAF), p == P_DA, p == P_LFD, p == P_LD,
            p == P_LAF, p == P_FFS, p == P_CPE, !(p == P_DA || p == P_LD)};
  endfunction

  function automatic int m_next(int p);
    if (p != P_DA && m_addr < 3 && m_soft[m_addr]) return P_DA;
    if (p == P_DA) begin
      if (!pkt_valid || data_in == 2'b11) return P_DA;
      return m_empty[data_in] ? P_LFD : P_WTE;
    end
    if (p == P_LFD) return P_LD;
    if (p == P_LD)  return fifo_full ? P_FFS : (!pkt_valid ? P_LP : P_LD);
    if (p == P_FFS) return fifo_full ? P_FFS : P_LAF;
    if (p == P_LAF) return parity_done ? P_DA : (low_pkt_valid ? P_LP : P_LD);
    if (p == P_LP)  return P_CPE;
    if (p == P_CPE) return fifo_full ? P_FFS : P_DA;
    if (p == P_WTE) return m_empty[m_addr] ? P_LFD : P_WTE;
    return P_DA;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_phase <= P_DA;
      m_addr  <= 0;
    end else begin
      m_phase <= m_next(m_phase);
      if (m_phase == P_DA && pkt_valid && data_in != 2'b11) m_addr <= int'(data_in);
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    parity_done = 0; low_pkt_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    tick();
    n_checks++;
    if (outs !== 8'b0100_0000) begin
      n_errors++; $display("FAIL reset_init: got %b want %b", outs, 8'b0100_0000);
    end
    resetn = 1;
    pkt_valid = 1; data_in = 2'd0;
    tick(); tick();
    n_checks++;
    if (outs !== outs_of(P_LD)) begin
      n_errors++; $display("FAIL reset_reach_ld: got %b want %b", outs, outs_of(P_LD));
    end
    #2 resetn = 0;
    #1;
    n_checks++;
    if (outs !== 8'b0100_0000) begin
      n_errors++; $display("FAIL reset_async: got %b want %b", outs, 8'b0100_0000);
    end
    @(negedge clock);
    resetn = 1;
    idle_inputs();
  endtask

  task automatic test_normal_packet();
    int seq[6] = '{P_LFD, P_LD, P_LD, P_LP, P_CPE, P_DA};
    int we_cnt = 0;
    int busy_lo = 0;
    idle_inputs();
    pkt_valid = 1; data_in = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (outs !== outs_of(seq[i])) begin
        n_errors++; $display("FAIL normal_step%0d: got %b want %b", i, outs, outs_of(seq[i]));
      end
      we_cnt  += int'(write_enb_reg);
      busy_lo += int'(!busy);
      if (i == 0) data_in = 2'b01;
      if (i == 1) data_in = 2'b10;
      if (i == 2) pkt_valid = 0;
    end
    n_checks++;
    if (we_cnt != 3) begin
      n_errors++; $display("FAIL normal_we_count: got %0d want 3", we_cnt);
    end
    n_checks++;
    if (busy_lo != 3) begin
      n_errors++; $display("FAIL normal_busy_low_count: got %0d want 3", busy_lo);
    end
  endtask

  task automatic test_busy_dest();
    idle_inputs();
    fifo_empty_2 = 0; pkt_valid = 1; data_in = 2'd2;
    tick();
    pkt_valid = 0; data_in = 2'd0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (outs !== outs_of(P_WTE)) begin
        n_errors++; $display("FAIL busy_wte%0d: got %b want %b", i, outs, outs_of(P_WTE));
      end
      if (i < 3) tick();
    end
    fifo_empty_2 = 1; pkt_valid = 1;
    tick();
    n_checks++;
    if (outs !== outs_of(P_LFD)) begin
      n_errors++; $display("FAIL busy_to_lfd: got %b want %b", outs, outs_of(P_LFD));
    end
    tick();
    pkt_valid = 0;
    tick(); tick(); tick();
    n_checks++;
    if (outs !== outs_of(P_DA)) begin
      n_errors++; $display("FAIL busy_return_da: got %b want %b", outs, outs_of(P_DA));
    end
  endtask

  task automatic test_fifo_full();
    int seq[10] = '{P_LFD, P_LD, P_FFS, P_FFS, P_LAF, P_LD, P_FFS, P_LAF, P_LP, P_CPE};
    idle_inputs();
    pkt_valid = 1; data_in = 2'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (outs !== outs_of(seq[i])) begin
        n_errors++; $display("FAIL full_step%0d: got %b want %b", i, outs, outs_of(seq[i]));
      end
      fifo_full     = (i == 1 || i == 2 || i == 5);
      low_pkt_valid = (i == 7);
      if (i == 7) pkt_valid = 0;
    end
    tick();
    n_checks++;
    if (outs !== outs_of(P_DA)) begin
      n_errors++; $display("FAIL full_return_da: got %b want %b", outs, outs_of(P_DA));
    end
  endtask

  task automatic test_addr3();
    idle_inputs();
    pkt_valid = 1; data_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (outs !== outs_of(P_DA)) begin
        n_errors++; $display("FAIL addr3_step%0d: got %b want %b", i, outs, outs_of(P_DA));
      end
    end
    pkt_valid = 0;
  endtask

  task automatic test_soft_reset();
    idle_inputs();
    pkt_valid = 1; data_in = 2'd0;
    tick(); tick();
    soft_reset_1 = 1;
    tick();
    n_checks++;
    if (outs !== outs_of(P_LD)) begin
      n_errors++; $display("FAIL soft_other_fifo: got %b want %b", outs, outs_of(P_LD));
    end
    soft_reset_1 = 0; soft_reset_0 = 1;
    tick();
    n_checks++;
    if (outs !== outs_of(P_DA)) begin
      n_errors++; $display("FAIL soft_own_fifo: got %b want %b", outs, outs_of(P_DA));
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      pkt_valid     = ($urandom % 4) != 0;
      data_in       = 2'($urandom);
      fifo_full     = ($urandom % 4) == 0;
      fifo_empty_0  = 1'($urandom);
      fifo_empty_1  = 1'($urandom);
      fifo_empty_2  = 1'($urandom);
      soft_reset_0  = ($urandom % 20) == 0;
      soft_reset_1  = ($urandom % 20) == 0;
      soft_reset_2  = ($urandom % 20) == 0;
      parity_done   = ($urandom % 4) == 0;
      low_pkt_valid = ($urandom % 3) == 0;
      resetn        = ($urandom % 150) != 0;
      tick();
      n_checks++;
      if (outs !== outs_of(m_phase)) begin
        n_errors++; $display("FAIL random_cyc%0d: got %b want %b", i, outs, outs_of(m_phase));
      end
    end
    resetn = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_normal_packet();
    test_busy_dest();
    test_fifo_full();
    test_addr3();
    test_soft_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
